// File: rtl/alu_issue_stage_if.sv
// Issue-stage handshake bundle: decode-side request and EX-side result.
// The stage itself takes the slave view, and the decode/EX side takes the master view.
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic            funct7_5;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd_in;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] A;
    logic [XLEN-1:0] B;
    logic [3:0]      ALUOp;
    logic [4:0]      rd_out;
    logic            illegal;

    modport master (
        output in_valid, opcode, funct3, funct7_5,
        output rs1_data, rs2_data, imm, rd_in,
        output flush, out_ready,
        input  in_ready, out_valid, A, B,
        input  ALUOp, rd_out, illegal
    );

    modport slave (
        input  in_valid, opcode, funct3, funct7_5,
        input  rs1_data, rs2_data, imm, rd_in,
        input  flush, out_ready,
        output in_ready, out_valid, A, B,
        output ALUOp, rd_out, illegal
    );
endinterface

// File: rtl/alu_issue_stage.sv
// ID->EX issue stage: decodes ALUOp and operand B, then registers the result
// in a main register backed by a one-entry skid buffer.
module alu_issue_stage #(
    parameter int XLEN = 32
) (
    input logic               clk,
    input logic               reset,
    alu_issue_stage_if.slave  bus
);
    typedef struct packed {
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [3:0]      op;
        logic [4:0]      rd;
        logic            ill;
    } ex_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SRL = 4'b1010;

    ex_t  m_q, s_q, dec;
    logic m_valid, s_valid;
    logic accept, m_free;
    logic use_imm;

    logic r_op, i_op, ls_op, br_op;
    logic f7;
    logic [2:0] f3;

    assign f7    = bus.funct7_5;
    assign f3    = bus.funct3;
    assign r_op  = bus.opcode == 7'b0110011;
    assign i_op  = bus.opcode == 7'b0010011;
    assign ls_op = bus.opcode == 7'b0000011
                || bus.opcode == 7'b0100011;
    assign br_op = bus.opcode == 7'b1100011;

    always_comb begin
        dec.op  = OP_ADD;
        dec.ill = 1'b0;
        use_imm = 1'b0;
        unique case (1'b1)
            r_op && f3 == 3'b000 && !f7: dec.op = OP_ADD;
            r_op && f3 == 3'b000 && f7:  dec.op = OP_SUB;
            r_op && f3 == 3'b111 && !f7: dec.op = OP_AND;
            r_op && f3 == 3'b110 && !f7: dec.op = OP_OR;
            r_op && f3 == 3'b101 && !f7: dec.op = OP_SRL;
            i_op && f3 == 3'b000: begin
                dec.op  = OP_ADD;
                use_imm = 1'b1;
            end
            i_op && f3 == 3'b111: begin
                dec.op  = OP_AND;
                use_imm = 1'b1;
            end
            i_op && f3 == 3'b110: begin
                dec.op  = OP_OR;
                use_imm = 1'b1;
            end
            i_op && f3 == 3'b101 && !f7: begin
                dec.op  = OP_SRL;
                use_imm = 1'b1;
            end
            ls_op: begin
                dec.op  = OP_ADD;
                use_imm = 1'b1;
            end
            br_op && (f3 == 3'b000 || f3 == 3'b001):
                dec.op = OP_SUB;
            default: dec.ill = 1'b1;
        endcase
        dec.a  = bus.rs1_data;
        dec.b  = use_imm ? bus.imm : bus.rs2_data;
        dec.rd = bus.rd_in;
    end

    // Depends only on registered state plus flush/reset, so a full skid
    // is what throttles decode.
    assign bus.in_ready = !s_valid && !bus.flush && !reset;
    assign accept       = bus.in_valid && bus.in_ready;
    assign m_free       = !m_valid || bus.out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_q     <= '0;
            s_q     <= '0;
        end else if (bus.flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (m_free) begin
            if (s_valid) begin
                m_q     <= s_q;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (accept) begin
                m_q     <= dec;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            s_q     <= dec;
            s_valid <= 1'b1;
        end
    end

    assign bus.out_valid = m_valid;
    assign bus.A         = m_q.a;
    assign bus.B         = m_q.b;
    assign bus.ALUOp     = m_q.op;
    assign bus.rd_out    = m_q.rd;
    assign bus.illegal   = m_q.ill;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: a two-deep in-order queue model checked every
// cycle, plus directed cases with literal expectations.
module tb_alu_issue_stage;
    logic clk = 1'b0;
    logic reset;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference decode, written straight from the opcode table.
    function automatic exp_t model(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic f7, input logic [31:0] r1,
                                   input logic [31:0] r2, input logic [31:0] im,
                                   input logic [4:0] rd);
        exp_t e;
        bit imm_b = 0;
        e.a = r1;
        e.rd = rd;
        e.ill = 0;
        e.op = 4'b0010;
        case (opc)
            7'b0110011:
                case ({f7, f3})
                    4'b0000: e.op = 4'b0010;
                    4'b1000: e.op = 4'b0110;
                    4'b0111: e.op = 4'b0000;
                    4'b0110: e.op = 4'b0001;
                    4'b0101: e.op = 4'b1010;
                    default: e.ill = 1;
                endcase
            7'b0010011: begin
                imm_b = 1;
                if (f3 == 3'b000) e.op = 4'b0010;
                else if (f3 == 3'b111) e.op = 4'b0000;
                else if (f3 == 3'b110) e.op = 4'b0001;
                else if (f3 == 3'b101 && !f7) e.op = 4'b1010;
                else begin
                    e.ill = 1;
                    imm_b = 0;
                end
            end
            7'b0000011, 7'b0100011: imm_b = 1;
            7'b1100011:
                if (f3 == 3'b000 || f3 == 3'b001) e.op = 4'b0110;
                else e.ill = 1;
            default: e.ill = 1;
        endcase
        e.b = imm_b ? im : r2;
        return e;
    endfunction

    // Every-cycle compare, then advance the model across the coming edge.
    always @(negedge clk) begin
        logic exp_rdy;
        exp_rdy = !reset && !bus.flush && q.size() < 2;
        check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        if (q.size() > 0) begin
            check("A", bus.A, q[0].a);
            check("B", bus.B, q[0].b);
            check("ALUOp", 32'(bus.ALUOp), 32'(q[0].op));
            check("rd_out", 32'(bus.rd_out), 32'(q[0].rd));
            check("illegal", 32'(bus.illegal), 32'(q[0].ill));
        end
        if (reset || bus.flush) begin
            q.delete();
        end else begin
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && exp_rdy)
                q.push_back(model(bus.opcode, bus.funct3, bus.funct7_5,
                                  bus.rs1_data, bus.rs2_data, bus.imm,
                                  bus.rd_in));
        end
    end

    task automatic drive(input logic v, input logic [6:0] opc,
                         input logic [2:0] f3, input logic f7,
                         input logic [31:0] r1, input logic [31:0] r2,
                         input logic [31:0] im, input logic [4:0] rd);
        bus.in_valid = v;
        bus.opcode   = opc;
        bus.funct3   = f3;
        bus.funct7_5 = f7;
        bus.rs1_data = r1;
        bus.rs2_data = r2;
        bus.imm      = im;
        bus.rd_in    = rd;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [6:0] pick_opc();
        logic [6:0] tbl [6];
        tbl[0] = 7'b0110011;
        tbl[1] = 7'b0010011;
        tbl[2] = 7'b0000011;
        tbl[3] = 7'b0100011;
        tbl[4] = 7'b1100011;
        tbl[5] = 7'($urandom);
        return tbl[$urandom_range(0, 5)];
    endfunction

    initial begin
        reset = 1'b1;
        bus.flush = 1'b0;
        bus.out_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        // Reset held two cycles
        step();
        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_ALUOp", 32'(bus.ALUOp), 0);
        check("rst_A", bus.A, 0);
        check("rst_B", bus.B, 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        step();
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", 32'(bus.in_ready), 1);

        // add 5 + 3
        step();
        bus.out_ready = 1'b1;
        drive(1, 7'b0110011, 3'b000, 0, 5, 3, 32'h99, 5'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("add_A", bus.A, 5);
        check("add_B", bus.B, 3);
        check("add_op", 32'(bus.ALUOp), 32'b0010);

        // srli then srai
        step();
        drive(1, 7'b0010011, 3'b101, 0, 32'h80, 32'h77, 4, 5'd2);
        step();
        drive(1, 7'b0010011, 3'b101, 1, 32'h80, 32'h77, 4, 5'd3);
        @(negedge clk);
        check("srli_op", 32'(bus.ALUOp), 32'b1010);
        check("srli_B", bus.B, 4);
        check("srli_ill", 32'(bus.illegal), 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("srai_ill", 32'(bus.illegal), 1);
        check("srai_op", 32'(bus.ALUOp), 32'b0010);

        // Backpressure: I1 in M, I2 in S, I3 held
        step();
        bus.out_ready = 1'b0;
        drive(1, 7'b0110011, 3'b000, 0, 11, 1, 0, 5'd11);
        step();
        drive(1, 7'b0110011, 3'b000, 0, 22, 2, 0, 5'd12);
        step();
        drive(1, 7'b0110011, 3'b000, 0, 33, 3, 0, 5'd13);
        @(negedge clk);
        check("bp_I1", bus.A, 11);
        check("bp_in_ready", 32'(bus.in_ready), 0);
        step();
        bus.out_ready = 1'b1;
        step();
        @(negedge clk);
        check("bp_I2", bus.A, 22);
        check("bp_ready_back", 32'(bus.in_ready), 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("bp_I3", bus.A, 33);

        // Flush with M and S full; input offered during flush is dropped
        step();
        bus.out_ready = 1'b0;
        drive(1, 7'b0010011, 3'b000, 0, 44, 0, 1, 5'd4);
        step();
        step();
        bus.flush = 1'b1;
        drive(1, 7'b0010011, 3'b000, 0, 55, 0, 1, 5'd5);
        @(negedge clk);
        check("fl_in_ready", 32'(bus.in_ready), 0);
        step();
        bus.flush = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("fl_out_valid", 32'(bus.out_valid), 0);
        check("fl_in_ready_back", 32'(bus.in_ready), 1);
        step();
        @(negedge clk);
        check("fl_not_taken", 32'(bus.out_valid), 0);

        // beq and lw
        step();
        bus.out_ready = 1'b1;
        drive(1, 7'b1100011, 3'b000, 0, 7, 7, 32'h10, 5'd0);
        step();
        drive(1, 7'b0000011, 3'b010, 0, 100, 9, 32'hFFFFFFFC, 5'd6);
        @(negedge clk);
        check("beq_op", 32'(bus.ALUOp), 32'b0110);
        check("beq_B", bus.B, 7);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check("lw_op", 32'(bus.ALUOp), 32'b0010);
        check("lw_B", bus.B, 32'hFFFFFFFC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            step();
            reset = ($urandom_range(0, 199) == 0);
            bus.flush = ($urandom_range(0, 39) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 6);
            drive($urandom_range(0, 9) < 7, pick_opc(), 3'($urandom),
                  1'($urandom), $urandom, $urandom, $urandom,
                  5'($urandom));
        end
        step();
        reset = 1'b0;
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        repeat (4) step();
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
